// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: request owner encoding and
// the in-flight read tag carried down the response pipe.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_LS = 1'b0,
        OWN_IO = 1'b1
    } owner_t;

    typedef struct packed {
        logic   vld;
        owner_t owner;
    } resp_tag_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_arb_resp_pipe.sv
// Read-response routing: a MEM_LATENCY-deep shift of in-flight read tags.
// The tag leaving the pipe selects which master sees mem_rdata.
module dmem_arb_resp_pipe
    import dmem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  resp_tag_t         tag_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata
);

    resp_tag_t pipe_q [MEM_LATENCY];
    resp_tag_t tail;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail = pipe_q[MEM_LATENCY-1];

    // The non-owning master always sees zero data.
    always_comb begin
        ls_rvalid = tail.vld & (tail.owner == OWN_LS);
        io_rvalid = tail.vld & (tail.owner == OWN_IO);
        ls_rdata  = ls_rvalid ? mem_rdata : '0;
        io_rdata  = io_rvalid ? mem_rdata : '0;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the load/store unit and an IO master.
// Define DMEM_ARB_RR_EN for round-robin; default is LS priority with IO starvation guard.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4,
    localparam int BE_W        = DATA_W / 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ls_valid,
    output logic                ls_ready,
    input  logic                ls_we,
    input  logic [BE_W-1:0]     ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    input  logic                io_valid,
    output logic                io_ready,
    input  logic                io_we,
    input  logic [BE_W-1:0]     io_be,
    input  logic [ADDR_W-1:0]   io_addr,
    input  logic [DATA_W-1:0]   io_wdata,
    output logic                io_rvalid,
    output logic [DATA_W-1:0]   io_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [BE_W-1:0]     mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [STARVE_W-1:0] starve_cnt
);

    // Handshake: a request transfers when x_valid & x_ready; x_ready is only
    // ever high for the granted master while mem_ready is high, and the
    // requester keeps valid and fields stable until that cycle.
    logic      io_wins;
    owner_t    grant;
    resp_tag_t tag_in;

`ifdef DMEM_ARB_RR_EN
    owner_t last_grant;

    // Reset to IO so the first contended cycle goes to LS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= OWN_IO;
        end else if (ls_ready | io_ready) begin
            last_grant <= grant;
        end
    end

    assign io_wins    = io_valid & (~ls_valid | (last_grant == OWN_LS));
    assign starve_cnt = '0;
`else
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;

    // Counts LS wins while IO waits; stalled memory cycles leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
        end else if (io_ready) begin
            starve_q <= '0;
        end else if (io_valid & ls_ready & (starve_q != LIMIT)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign io_wins    = io_valid & (~ls_valid | (starve_q == LIMIT));
    assign starve_cnt = starve_q;
`endif

    always_comb begin
        grant     = OWN_LS;
        ls_ready  = 1'b0;
        io_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            grant    = io_wins ? OWN_IO : OWN_LS;
            ls_ready = mem_ready & ls_valid & ~io_wins;
            io_ready = mem_ready & io_wins;
            mem_en   = (ls_valid | io_valid) & mem_ready;
            if (io_wins) begin
                mem_we    = io_we;
                mem_be    = io_be;
                mem_addr  = io_addr;
                mem_wdata = io_wdata;
            end else if (ls_valid) begin
                mem_we    = ls_we;
                mem_be    = ls_be;
                mem_addr  = ls_addr;
                mem_wdata = ls_wdata;
            end
        end
    end

    always_comb begin
        tag_in.vld   = mem_en & ~mem_we;
        tag_in.owner = grant;
    end

    dmem_arb_resp_pipe #(
        .MEM_LATENCY (MEM_LATENCY),
        .DATA_W      (DATA_W)
    ) u_resp_pipe (
        .clk       (clk),
        .reset     (reset),
        .tag_in    (tag_in),
        .mem_rdata (mem_rdata),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .io_rvalid (io_rvalid),
        .io_rdata  (io_rdata)
    );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (MEM_LATENCY 1 and 2) share one
// stimulus stream; a request/response model checks both every cycle.
module tb_dmem_port_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        ls_valid, ls_we, io_valid, io_we, mem_ready;
    logic [3:0]  ls_be, io_be;
    logic [31:0] ls_addr, ls_wdata, io_addr, io_wdata;

    logic        a_ls_ready, a_ls_rvalid, a_io_ready, a_io_rvalid, a_mem_en, a_mem_we;
    logic [31:0] a_ls_rdata, a_io_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_be, a_starve;
    logic        b_ls_ready, b_ls_rvalid, b_io_ready, b_io_rvalid, b_mem_en, b_mem_we;
    logic [31:0] b_ls_rdata, b_io_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_be, b_starve;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) u_dut_a (
        .clk(clk), .reset(reset),
        .ls_valid(ls_valid), .ls_ready(a_ls_ready), .ls_we(ls_we), .ls_be(ls_be),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
        .io_valid(io_valid), .io_ready(a_io_ready), .io_we(io_we), .io_be(io_be),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rvalid(a_io_rvalid), .io_rdata(a_io_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_ready(mem_ready), .mem_rdata(a_mem_rdata),
        .starve_cnt(a_starve)
    );

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(LIMIT)) u_dut_b (
        .clk(clk), .reset(reset),
        .ls_valid(ls_valid), .ls_ready(b_ls_ready), .ls_we(ls_we), .ls_be(ls_be),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
        .io_valid(io_valid), .io_ready(b_io_ready), .io_we(io_we), .io_be(io_be),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rvalid(b_io_rvalid), .io_rdata(b_io_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_ready(mem_ready), .mem_rdata(b_mem_rdata),
        .starve_cnt(b_starve)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        bit          own_io;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic        ls_ready;
        logic        io_ready;
        logic        mem_en;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  starve;
        logic        ls_rvalid;
        logic [31:0] ls_rdata;
        logic        io_rvalid;
        logic [31:0] io_rdata;
    } obs_t;

    req_t        ls_q[$], io_q[$];
    rsp_t        rq_a[$], rq_b[$];
    logic [31:0] ram_m[logic [31:0]];
    logic [31:0] ram_a[logic [31:0]];
    logic [31:0] ram_b[logic [31:0]];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_n   = 0;
    int   starve_m = 0;
    bit   last_io = 1'b1;
    bit   pop_ls  = 1'b0;
    bit   pop_io  = 1'b0;
    logic mr      = 1'b1;

    obs_t obs_a, obs_b;

    always_comb begin
        obs_a = '{a_ls_ready, a_io_ready, a_mem_en, a_mem_we, a_mem_be, a_mem_addr,
                  a_mem_wdata, a_starve, a_ls_rvalid, a_ls_rdata, a_io_rvalid, a_io_rdata};
        obs_b = '{b_ls_ready, b_io_ready, b_mem_en, b_mem_we, b_mem_be, b_mem_addr,
                  b_mem_wdata, b_starve, b_ls_rvalid, b_ls_rdata, b_io_rvalid, b_io_rdata};
    end

    // Untouched RAM words hold a pattern derived from their address.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = w[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, exp);
        end
    endtask

    task automatic cmp_obs(input string p, input obs_t act, input obs_t e);
        chk({p, "_ls_ready"},  32'(act.ls_ready),  32'(e.ls_ready));
        chk({p, "_io_ready"},  32'(act.io_ready),  32'(e.io_ready));
        chk({p, "_mem_en"},    32'(act.mem_en),    32'(e.mem_en));
        chk({p, "_mem_we"},    32'(act.mem_we),    32'(e.mem_we));
        chk({p, "_mem_be"},    32'(act.mem_be),    32'(e.mem_be));
        chk({p, "_mem_addr"},  act.mem_addr,       e.mem_addr);
        chk({p, "_mem_wdata"}, act.mem_wdata,      e.mem_wdata);
        chk({p, "_starve"},    32'(act.starve),    32'(e.starve));
        chk({p, "_ls_rvalid"}, 32'(act.ls_rvalid), 32'(e.ls_rvalid));
        chk({p, "_ls_rdata"},  act.ls_rdata,       e.ls_rdata);
        chk({p, "_io_rvalid"}, 32'(act.io_rvalid), 32'(e.io_rvalid));
        chk({p, "_io_rdata"},  act.io_rdata,       e.io_rdata);
    endtask

    // Memory environment: each instance gets its own RAM and read-data delay line.
    logic [31:0] na = 32'hDEAD_BEEF;
    logic [31:0] nb = 32'hDEAD_BEEF;
    logic [31:0] b_d1 = 32'hDEAD_BEEF;

    always @(negedge clk) begin
        na = 32'hDEAD_BEEF;
        nb = 32'hDEAD_BEEF;
        if (a_mem_en) begin
            if (a_mem_we)
                ram_a[a_mem_addr] = merge(ram_a.exists(a_mem_addr) ? ram_a[a_mem_addr] : dflt(a_mem_addr),
                                          a_mem_wdata, a_mem_be);
            else
                na = ram_a.exists(a_mem_addr) ? ram_a[a_mem_addr] : dflt(a_mem_addr);
        end
        if (b_mem_en) begin
            if (b_mem_we)
                ram_b[b_mem_addr] = merge(ram_b.exists(b_mem_addr) ? ram_b[b_mem_addr] : dflt(b_mem_addr),
                                          b_mem_wdata, b_mem_be);
            else
                nb = ram_b.exists(b_mem_addr) ? ram_b[b_mem_addr] : dflt(b_mem_addr);
        end
    end

    initial begin
        a_mem_rdata = 32'hDEAD_BEEF;
        b_mem_rdata = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        a_mem_rdata <= na;
        b_d1        <= nb;
        b_mem_rdata <= b_d1;
    end

    // Model: decide the winner from the arbitration rules, predict every
    // output, then apply the effects of this cycle's accept.
    always @(negedge clk) begin : model_cmp
        obs_t        e, ea, eb;
        logic        io_win;
        logic [31:0] rdat;
        rsp_t        r;
        e = '0;
        if (reset !== 1'b1) begin
            rq_a.delete();
            rq_b.delete();
            starve_m = 0;
            last_io  = 1'b1;
            pop_ls   = 1'b0;
            pop_io   = 1'b0;
            cmp_obs("a", obs_a, e);
            cmp_obs("b", obs_b, e);
        end else begin
`ifdef DMEM_ARB_RR_EN
            io_win = io_valid && (!ls_valid || !last_io);
`else
            io_win = io_valid && (!ls_valid || starve_m == LIMIT);
`endif
            e.mem_en   = (ls_valid || io_valid) && mem_ready;
            e.ls_ready = mem_ready && ls_valid && !io_win;
            e.io_ready = mem_ready && io_win;
            if (io_win) begin
                e.mem_we = io_we; e.mem_be = io_be; e.mem_addr = io_addr; e.mem_wdata = io_wdata;
            end else if (ls_valid) begin
                e.mem_we = ls_we; e.mem_be = ls_be; e.mem_addr = ls_addr; e.mem_wdata = ls_wdata;
            end
`ifdef DMEM_ARB_RR_EN
            e.starve = 4'd0;
`else
            e.starve = 4'(starve_m);
`endif
            ea = e;
            eb = e;
            if (rq_a.size() > 0 && rq_a[0].due == cyc_n) begin
                r = rq_a.pop_front();
                if (r.own_io) begin ea.io_rvalid = 1'b1; ea.io_rdata = r.data; end
                else          begin ea.ls_rvalid = 1'b1; ea.ls_rdata = r.data; end
            end
            if (rq_b.size() > 0 && rq_b[0].due == cyc_n) begin
                r = rq_b.pop_front();
                if (r.own_io) begin eb.io_rvalid = 1'b1; eb.io_rdata = r.data; end
                else          begin eb.ls_rvalid = 1'b1; eb.ls_rdata = r.data; end
            end
            cmp_obs("a", obs_a, ea);
            cmp_obs("b", obs_b, eb);

            if (e.ls_ready || e.io_ready) begin
                if (e.mem_we) begin
                    ram_m[e.mem_addr] = merge(ram_m.exists(e.mem_addr) ? ram_m[e.mem_addr] : dflt(e.mem_addr),
                                              e.mem_wdata, e.mem_be);
                end else begin
                    rdat = ram_m.exists(e.mem_addr) ? ram_m[e.mem_addr] : dflt(e.mem_addr);
                    rq_a.push_back('{cyc_n + 1, io_win, rdat});
                    rq_b.push_back('{cyc_n + 2, io_win, rdat});
                end
                last_io = io_win;
            end
            if (e.io_ready)
                starve_m = 0;
            else if (io_valid && e.ls_ready && starve_m < LIMIT)
                starve_m = starve_m + 1;
            pop_ls = e.ls_ready;
            pop_io = e.io_ready;
        end
        cyc_n++;
    end

    // Driver: retire heads the model saw accepted, then present current heads.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (pop_ls && ls_q.size() > 0) void'(ls_q.pop_front());
        if (pop_io && io_q.size() > 0) void'(io_q.pop_front());
        if (ls_q.size() > 0) begin
            ls_valid = 1'b1; ls_we = ls_q[0].we; ls_be = ls_q[0].be;
            ls_addr = ls_q[0].addr; ls_wdata = ls_q[0].wdata;
        end else begin
            ls_valid = 1'b0; ls_we = 1'b1; ls_be = 4'hF;
            ls_addr = 32'hFFFF_FFFF; ls_wdata = 32'hFFFF_FFFF;
        end
        if (io_q.size() > 0) begin
            io_valid = 1'b1; io_we = io_q[0].we; io_be = io_q[0].be;
            io_addr = io_q[0].addr; io_wdata = io_q[0].wdata;
        end else begin
            io_valid = 1'b0; io_we = 1'b1; io_be = 4'hF;
            io_addr = 32'hEEEE_EEEE; io_wdata = 32'hEEEE_EEEE;
        end
        mem_ready = mr;
    endtask

    task automatic apply_reset();
        ls_q.delete();
        io_q.delete();
        mr = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((ls_q.size() > 0 || io_q.size() > 0) && k < 60) begin
            cyc();
            k++;
        end
        if (ls_q.size() > 0 || io_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout cycle %0d: %0d requests left, expected 0",
                     cyc_n, ls_q.size() + io_q.size());
        end
        repeat (4) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s2_st[6];
        int s2_io[6];
        int s7_io[4];
        ls_valid = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
        io_valid = 1'b0; io_we = 1'b0; io_be = '0; io_addr = '0; io_wdata = '0;
        mem_ready = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;
`ifdef DMEM_ARB_RR_EN
        s2_st = '{0, 0, 0, 0, 0, 0};
        s2_io = '{0, 1, 0, 1, 0, 0};
        s7_io = '{0, 1, 0, 1};
`else
        s2_st = '{0, 1, 2, 3, 4, 0};
        s2_io = '{0, 0, 0, 0, 1, 0};
        s7_io = '{0, 0, 0, 0};
`endif
        apply_reset();

        // LS-only load: accepted at once, data next cycle on the latency-1 port
        ls_q.push_back('{1'b0, 4'hF, 32'h100, 32'h0});
        cyc(); #2;
        chk("s1_ls_ready", 32'(a_ls_ready), 32'd1);
        cyc(); #2;
        chk("s1_ls_rvalid", 32'(a_ls_rvalid), 32'd1);
        chk("s1_ls_rdata", a_ls_rdata, 32'hC1DE_0100);
        chk("s1_io_rvalid", 32'(a_io_rvalid), 32'd0);
        drain();

        // Contention: IO forced in once the starvation count hits the limit
        apply_reset();
        for (int i = 0; i < 6; i++)
            ls_q.push_back('{1'b1, 4'hF, 32'h200 + 32'(4 * i), 32'h5000_0000 + 32'(i)});
        io_q.push_back('{1'b0, 4'hF, 32'h300, 32'h0});
        io_q.push_back('{1'b0, 4'hF, 32'h304, 32'h0});
        for (int c = 0; c < 6; c++) begin
            cyc(); #2;
            chk($sformatf("s2_starve_%0d", c), 32'(a_starve), 32'(s2_st[c]));
            chk($sformatf("s2_io_ready_%0d", c), 32'(a_io_ready), 32'(s2_io[c]));
        end
        drain();

        // Memory stall: nothing accepted, count frozen, order kept afterwards
        apply_reset();
        ls_q.push_back('{1'b0, 4'hF, 32'h400, 32'h0});
        ls_q.push_back('{1'b0, 4'hF, 32'h404, 32'h0});
        ls_q.push_back('{1'b0, 4'hF, 32'h408, 32'h0});
        io_q.push_back('{1'b0, 4'hF, 32'h500, 32'h0});
        cyc();
        cyc();
        mr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc(); #2;
`ifdef DMEM_ARB_RR_EN
            chk("s3_starve_hold", 32'(a_starve), 32'd0);
`else
            chk("s3_starve_hold", 32'(a_starve), 32'd2);
`endif
            chk("s3_ls_ready", 32'(a_ls_ready), 32'd0);
            chk("s3_io_ready", 32'(a_io_ready), 32'd0);
            chk("s3_mem_en", 32'(a_mem_en), 32'd0);
        end
        mr = 1'b1;
        cyc(); #2;
        chk("s3_resume_ls", 32'(a_ls_ready), 32'd1);
        drain();

        // Latency 2 back-to-back reads with alternating owners
        apply_reset();
        ls_q.push_back('{1'b0, 4'hF, 32'h10, 32'h0});
        cyc();
        io_q.push_back('{1'b0, 4'hF, 32'h20, 32'h0});
        cyc();
        ls_q.push_back('{1'b0, 4'hF, 32'h30, 32'h0});
        cyc(); #2;
        chk("s4_ls_ready_c2", 32'(b_ls_ready), 32'd1);
        chk("s4_ls_rvalid_c2", 32'(b_ls_rvalid), 32'd1);
        chk("s4_ls_rdata_c2", b_ls_rdata, 32'hC0CE_0010);
        cyc(); #2;
        chk("s4_io_rvalid_c3", 32'(b_io_rvalid), 32'd1);
        chk("s4_io_rdata_c3", b_io_rdata, 32'hC0FE_0020);
        chk("s4_ls_rvalid_c3", 32'(b_ls_rvalid), 32'd0);
        cyc(); #2;
        chk("s4_ls_rvalid_c4", 32'(b_ls_rvalid), 32'd1);
        chk("s4_ls_rdata_c4", b_ls_rdata, 32'hC0EE_0030);
        drain();

        // Reset with a read in flight drops the response
        apply_reset();
        ls_q.push_back('{1'b0, 4'hF, 32'h600, 32'h0});
        cyc();
        io_q.push_back('{1'b0, 4'hF, 32'h700, 32'h0});
        cyc();
        reset = 1'b0;
        #2;
        chk("s5_rst_io_ready", 32'(b_io_ready), 32'd0);
        chk("s5_rst_mem_en", 32'(b_mem_en), 32'd0);
        chk("s5_rst_mem_addr", b_mem_addr, 32'h0);
        chk("s5_rst_a_rvalid", 32'(a_ls_rvalid), 32'd0);
        chk("s5_rst_starve", 32'(b_starve), 32'd0);
        cyc();
        reset = 1'b1;
        #2;
        chk("s5_b_rvalid_dropped", 32'(b_ls_rvalid), 32'd0);
        chk("s5_io_after_reset", 32'(b_io_ready), 32'd1);
        cyc(); #2;
        chk("s5_b_rvalid_late", 32'(b_ls_rvalid), 32'd0);
        drain();

        // Partial store then readback through the other master
        apply_reset();
        ls_q.push_back('{1'b1, 4'b0011, 32'h44, 32'hAAAA_5555});
        cyc();
        io_q.push_back('{1'b0, 4'hF, 32'h44, 32'h0});
        cyc();
        cyc(); #2;
        chk("s6_io_rvalid", 32'(a_io_rvalid), 32'd1);
        chk("s6_io_rdata", a_io_rdata, 32'hC09A_5555);
        drain();

        // Both masters requesting for four cycles: grant pattern
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            ls_q.push_back('{1'b0, 4'hF, 32'h800 + 32'(4 * i), 32'h0});
            io_q.push_back('{1'b0, 4'hF, 32'h900 + 32'(4 * i), 32'h0});
        end
        for (int c = 0; c < 4; c++) begin
            cyc(); #2;
            chk($sformatf("s7_io_grant_%0d", c), 32'(a_io_ready), 32'(s7_io[c]));
            chk($sformatf("s7_ls_grant_%0d", c), 32'(a_ls_ready), 32'(1 - s7_io[c]));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
